// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb_if
// Purpose  : Bundles the producer request bus, the baud strobe and the
//            uart_tx handshake used by the uart_tx_arb frame sequencer.
// Modports : master - producer/test side (drives requests and baud_tick)
//            slave  - arbiter side (drives acks and the uart_tx handshake)
// Signals  : baud_tick      one-cycle strobe from baud_gen
//            req_valid      per-requester request, held until acked
//            req_data       byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//            req_ack        one-hot, one-cycle grant pulse
//            tx_data_ready  to uart_tx.data_ready
//            tx_data_in     to uart_tx.data_in
//            busy           high while a frame is in flight
//            active_id      current or last granted requester
//            frame_done     one-cycle pulse on return to idle
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                             baud_tick;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
  logic [NUM_REQ-1:0]               req_ack;
  logic                             tx_data_ready;
  logic [DATA_WIDTH-1:0]            tx_data_in;
  logic                             busy;
  logic [ID_W-1:0]                  active_id;
  logic                             frame_done;

  modport master (
    output baud_tick, req_valid, req_data,
    input  req_ack, tx_data_ready, tx_data_in, busy, active_id, frame_done
  );

  modport slave (
    input  baud_tick, req_valid, req_data,
    output req_ack, tx_data_ready, tx_data_in, busy, active_id, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Purpose  : Shares one uart_tx between NUM_REQ byte producers. Picks a
//            requester, latches its byte, holds uart_tx data_ready across one
//            baud tick and counts ticks until the frame plus the idle gap have
//            left the line (uart_tx has no busy flag of its own).
// Ports    : clk  - system clock
//            rst  - synchronous, active-high reset
//            bus  - uart_tx_arb_if.slave (requests, baud_tick, uart_tx side)
// Options  : UART_ARB_FIXED_PRIO_EN - when defined, the lowest-index valid
//            requester always wins; otherwise round-robin starting after the
//            last granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int BITS_PER_FRAME = 11,
  parameter int GAP_TICKS      = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  uart_tx_arb_if.slave   bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BITS_PER_FRAME + GAP_TICKS + 1);

  // Count values seen on the tick that completes the data frame / the gap.
  localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(BITS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(BITS_PER_FRAME + GAP_TICKS - 1);
  localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    found;
  logic [ID_W-1:0]         win_id;
  logic [DATA_WIDTH-1:0]   win_data;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef UART_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest-index valid requester is the last to write.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant_q;

  // Search starts one past the last grant and wraps; reset value NUM_REQ-1
  // gives requester 0 the first turn.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    win_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else if (state_q == S_IDLE && found) begin
      last_grant_q <= win_id;
    end
  end
`endif

  // Byte mux with constant slice bounds.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer: next state / outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    ready_d = ready_q;
    data_d  = data_q;
    id_d    = id_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOAD;
          ready_d = 1'b1;
          data_d  = win_data;
          id_d    = win_id;
          ack_d   = C_ONE << win_id;
        end
      end

      // A tick on the grant edge was seen in IDLE, so the launch tick is
      // always the first one observed here.
      S_LOAD: begin
        if (bus.baud_tick) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.baud_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_FRAME_LAST) begin
            if (GAP_TICKS == 0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end

      // The counter keeps running through the gap, hence its width covers
      // BITS_PER_FRAME + GAP_TICKS.
      S_GAP: begin
        if (bus.baud_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_GAP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      id_q    <= id_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ack       = ack_q;
  assign bus.tx_data_ready = ready_q;
  assign bus.tx_data_in    = data_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.active_id     = id_q;
  assign bus.frame_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arb
// Purpose  : Randomized self-checking bench for uart_tx_arb. A transaction
//            model (grant rule + count of baud ticks since the grant) predicts
//            every output each cycle. An opening directed window presents all
//            four requesters at once with fixed bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int NR       = 4;
  localparam int DW       = 8;
  localparam int BITS     = 11;
  localparam int GAP      = 1;
  localparam int IDW      = 2;
  localparam int NCYC     = 4000;
  localparam int DIRECTED = 220;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BITS_PER_FRAME(BITS), .GAP_TICKS(GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic          m_busy, m_ready, m_done;
  logic [NR-1:0] m_ack;
  logic [DW-1:0] m_data;
  logic [IDW-1:0] m_id;
  int            m_last;
  int            m_ticks;

  // Requester side
  logic [NR-1:0] v;
  logic [DW-1:0] d [NR];
  logic          tick;
  int            granted[$];
  int            total_grants = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] vv);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++)
      if (vv[i]) return i;
`else
    for (int k = 1; k <= NR; k++)
      if (vv[(m_last + k) % NR]) return (m_last + k) % NR;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_done = 0; m_ack = '0;
    m_data = '0; m_id = '0; m_last = NR - 1; m_ticks = 0;
  endtask

  // One clock edge at transaction level: grant when free, else count ticks.
  // Tick 1 after the grant is the launch; the frame ends after BITS+GAP more.
  task automatic model_step(input logic r, input logic [NR-1:0] vv, input logic t);
    int w;
    if (r) begin
      model_reset();
    end else begin
      m_ack  = '0;
      m_done = 0;
      if (!m_busy) begin
        w = pick(vv);
        if (w >= 0) begin
          m_busy  = 1;
          m_ready = 1;
          m_data  = d[w];
          m_id    = IDW'(w);
          m_last  = w;
          m_ack[w] = 1'b1;
          m_ticks = 0;
        end
      end else if (t) begin
        m_ticks++;
        if (m_ticks == 1) m_ready = 0;
        if (m_ticks == 1 + BITS + GAP) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = d[i];
    bus.req_valid = v;
    bus.baud_tick = tick;
  endtask

  initial begin
    rst  = 1'b1;
    v    = '0;
    tick = 1'b0;
    for (int i = 0; i < NR; i++) d[i] = '0;
    drive_bus();
    model_reset();
    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_val("ack",   32'(bus.req_ack),       32'(m_ack));
      check_val("ready", 32'(bus.tx_data_ready), 32'(m_ready));
      check_val("data",  32'(bus.tx_data_in),    32'(m_data));
      check_val("busy",  32'(bus.busy),          32'(m_busy));
      check_val("id",    32'(bus.active_id),     32'(m_id));
      check_val("done",  32'(bus.frame_done),    32'(m_done));

      for (int i = 0; i < NR; i++)
        if (bus.req_ack[i]) begin
          granted.push_back(i);
          total_grants++;
        end

      if (cyc == DIRECTED - 1) begin
        check_val("order_cnt", 32'(granted.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
          if (i < granted.size())
            check_val($sformatf("order%0d", i), 32'(granted[i]), 32'(i));
      end

      rst = 1'b0;
      // Acked requesters drop; in the random phase some re-offer at once.
      for (int i = 0; i < NR; i++)
        if (m_ack[i]) begin
          v[i] = 1'b0;
          if (cyc >= DIRECTED && ($urandom % 3) == 0) begin
            v[i] = 1'b1;
            d[i] = DW'($urandom);
          end
        end

      if (cyc == 0) begin
        v    = 4'hF;
        d[0] = 8'h43; d[1] = 8'h72; d[2] = 8'hA5; d[3] = 8'hE7;
      end

      if (cyc < DIRECTED) begin
        tick = ((cyc % 3) == 2);
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (!v[i] && !m_ack[i] && ($urandom % 40) == 0) begin
            v[i] = 1'b1;
            d[i] = DW'($urandom);
          end else if (v[i] && !m_ack[i] && ($urandom % 200) == 0) begin
            v[i] = 1'b0;
          end
        end
        tick = (($urandom % 4) == 0);
        rst  = (($urandom % 500) == 0);
      end

      drive_bus();
      model_step(rst, v, tick);
    end

    check_val("grants", 32'(total_grants > 20), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
